spi_slave_if: RTL and testbench

RTL SPI responder for the multi-lane SPI link (1/2/4 lanes, SPI mode 0, LSB-lane-group first, 16- or 32-bit words, optional burst with cs_n held low).
- Oversamples spi_sclk, spi_cs_n and spi_mosi in the clk domain.
- Assembles received words and presents them on a valid/ready port.
- Shifts transmit words out on spi_miso.
- Sits between the external SPI pins and the accelerator's register/command front-end.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_if.sv | 193 +++++++++++++++++++
 tb/tb_spi_slave_if.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared encodings for the multi-lane SPI responder: lane modes, word lengths, FSM states.
package spi_pkg;

  localparam logic [1:0] LANE_1 = 2'd0;
  localparam logic [1:0] LANE_2 = 2'd1;
  localparam logic [1:0] LANE_4 = 2'd2;

  localparam logic [5:0] W16 = 6'd16;
  localparam logic [5:0] W32 = 6'd32;

  typedef enum logic [1:0] {StIdle, StLoad, StShift} spi_state_e;

  // Reserved mode 3 falls through to the 4-lane setting.
  function automatic logic [5:0] lane_count(input logic [1:0] mode);
    case (mode)
      LANE_1:  lane_count = 6'd1;
      LANE_2:  lane_count = 6'd2;
      default: lane_count = 6'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] mode);
    case (mode)
      LANE_1:  lane_mask = 4'b0001;
      LANE_2:  lane_mask = 4'b0011;
      LANE_4:  lane_mask = 4'b1111;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered one-clk rise/fall strobes.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  // Top bit holds the previous synchronised value for edge comparison.
  logic [SYNC_STAGES:0] sync_q;
  logic                 rise_q;
  logic                 fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-1:0], din};
      rise_q <= sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
      fall_q <= ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 responder with 1/2/4 lanes and 16/32-bit words, oversampled in the clk domain.
// MAX_W must be at least 32.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic [3:0]       spi_mosi,
  output logic [3:0]       spi_miso,
  input  logic [1:0]       lane_mode,
  input  logic             word32,
  output logic [MAX_W-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overflow,
  input  logic [MAX_W-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_err
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (spi_sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (spi_cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  logic [3:0] mosi_q [SYNC_STAGES];
  logic [3:0] mosi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) mosi_q[i] <= '0;
    end else begin
      mosi_q[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) mosi_q[i] <= mosi_q[i-1];
    end
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  spi_state_e       state_q;
  logic [1:0]       cfg_mode_q;
  logic             cfg_w32_q;
  logic [5:0]       bit_cnt_q;
  logic             word_start_q;
  logic [31:0]      tx_sh_q;
  logic [31:0]      rx_sh_q;
  logic [3:0]       miso_q;
  logic [MAX_W-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             rx_overflow_q;
  logic             tx_ready_q;
  logic             tx_underrun_q;
  logic             frame_err_q;

  logic [5:0]  lanes;
  logic [3:0]  mask;
  logic [5:0]  wlen;
  logic [5:0]  bit_cnt_nxt;
  logic [31:0] rx_word;
  logic [31:0] tx_load;
  logic [31:0] tx_next;
  logic        word_done;

  assign lanes       = lane_count(cfg_mode_q);
  assign mask        = lane_mask(cfg_mode_q);
  assign wlen        = cfg_w32_q ? W32 : W16;
  assign bit_cnt_nxt = bit_cnt_q + lanes;
  assign rx_word     = rx_sh_q | ({28'b0, mosi_s & mask} << bit_cnt_q);
  assign tx_load     = !tx_valid ? 32'b0 :
                       cfg_w32_q ? tx_data[31:0] : {16'b0, tx_data[15:0]};
  assign tx_next     = tx_sh_q >> lanes;
  // A completing rise loses to a simultaneous cs_rise: the frame is already over.
  assign word_done   = (state_q == StShift) && sclk_rise && !cs_rise && (bit_cnt_nxt == wlen);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cfg_mode_q    <= LANE_1;
      cfg_w32_q     <= 1'b0;
      bit_cnt_q     <= '0;
      word_start_q  <= 1'b0;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      miso_q        <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overflow_q <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_overflow_q <= 1'b0;

      // Single-entry receive buffer; a full, unread buffer keeps its old word.
      if (word_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= MAX_W'(rx_word);
          rx_valid_q <= 1'b1;
        end else begin
          rx_overflow_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      if (cs_rise) begin
        state_q      <= StIdle;
        miso_q       <= '0;
        bit_cnt_q    <= '0;
        rx_sh_q      <= '0;
        word_start_q <= 1'b0;
        frame_err_q  <= (bit_cnt_q != '0);
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              cfg_mode_q <= lane_mode;
              cfg_w32_q  <= word32;
              state_q    <= StLoad;
            end
          end
          StLoad: begin
            tx_sh_q       <= tx_load;
            miso_q        <= tx_load[3:0] & mask;
            tx_ready_q    <= tx_valid;
            tx_underrun_q <= !tx_valid;
            bit_cnt_q     <= '0;
            rx_sh_q       <= '0;
            word_start_q  <= 1'b0;
            state_q       <= StShift;
          end
          StShift: begin
            if (sclk_rise) begin
              if (word_done) begin
                bit_cnt_q    <= '0;
                rx_sh_q      <= '0;
                word_start_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_nxt;
                rx_sh_q   <= rx_word;
              end
            end else if (sclk_fall) begin
              if (word_start_q) begin
                // Burst continuation: next word is fetched exactly as on frame start.
                tx_sh_q       <= tx_load;
                miso_q        <= tx_load[3:0] & mask;
                tx_ready_q    <= tx_valid;
                tx_underrun_q <= !tx_valid;
                word_start_q  <= 1'b0;
              end else begin
                tx_sh_q <= tx_next;
                miso_q  <= tx_next[3:0] & mask;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign spi_miso    = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overflow = rx_overflow_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: directed vector table, corner sequences, random frames.
module tb_spi_slave_if;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic [3:0]  spi_mosi = '0;
  logic [3:0]  spi_miso;
  logic [1:0]  lane_mode = '0;
  logic        word32 = 1'b0;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        rx_overflow;
  logic [31:0] tx_data;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx_underrun;
  logic        frame_err;

  always #5 clk = ~clk;

  spi_slave_if #(.SYNC_STAGES(2), .MAX_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .lane_mode  (lane_mode),
    .word32     (word32),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overflow(rx_overflow),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .frame_err  (frame_err)
  );

  // Transmit words come from a pool; the monitor advances the index on each capture.
  logic [31:0] tx_pool [16];
  logic [3:0]  tx_idx = '0;
  assign tx_data = tx_pool[tx_idx];

  int          n_chk = 0;
  int          n_fail = 0;
  int          c_txr = 0, c_unr = 0, c_ovf = 0, c_ferr = 0;
  int          lane_junk = 0;
  logic [31:0] rx_got [$];
  logic [31:0] tx_exp [$];
  logic [31:0] m_words [4];
  logic [31:0] m_got [4];
  logic        rdy_rand = 1'b0;
  logic        rdy_fix = 1'b1;

  always @(posedge clk) begin
    #1;
    rx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  // Observe DUT outputs mid-low-phase; records what the master should see on miso.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (tx_ready) begin
        tx_exp.push_back(tx_data);
        c_txr++;
        tx_idx = tx_idx + 4'd1;
      end
      if (tx_underrun) begin
        tx_exp.push_back(32'h0);
        c_unr++;
      end
      if (rx_overflow) c_ovf++;
      if (frame_err) c_ferr++;
      if (rx_valid && rx_ready) rx_got.push_back(rx_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic refill_pool(input logic [31:0] first);
    for (int i = 0; i < 16; i++) tx_pool[i] = $urandom;
    tx_pool[tx_idx] = first;
  endtask

  // Master model: nwords full words, then an optional partial word of cut bits.
  task automatic frame(input logic [1:0] mode, input logic w32, input int nwords, input int cut);
    int          lanes, wl, nb;
    logic [3:0]  msk;
    logic [31:0] word, got;
    lanes = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
    msk = 4'((1 << lanes) - 1);
    wl = w32 ? 32 : 16;
    lane_mode = mode;
    word32 = w32;
    spi_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    for (int w = 0; w <= nwords; w++) begin
      nb = (w < nwords) ? wl : cut;
      word = m_words[w];
      got = '0;
      for (int b = 0; b < nb; b += lanes) begin
        spi_sclk = 1'b0;
        spi_mosi = (4'(word >> b) & msk) | (4'($urandom) & ~msk);
        repeat (HALF) @(negedge clk);
        got |= 32'(spi_miso & msk) << b;
        if ((spi_miso & ~msk) != 4'b0) lane_junk++;
        spi_sclk = 1'b1;
        repeat (HALF) @(negedge clk);
      end
      if (w < nwords) m_got[w] = got;
    end
    spi_cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_check(input string tag, input logic [1:0] mode, input logic w32,
                           input int nwords, input int cut, input int e_rx, input int e_txr,
                           input int e_unr, input int e_ovf, input int e_ferr);
    int          rb, tb0, b_txr, b_unr, b_ovf, b_ferr, b_junk;
    logic [31:0] wm, exp;
    wm = w32 ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    rb = rx_got.size();
    tb0 = tx_exp.size();
    b_txr = c_txr; b_unr = c_unr; b_ovf = c_ovf; b_ferr = c_ferr; b_junk = lane_junk;
    frame(mode, w32, nwords, cut);
    check({tag, " rx_words"}, 32'(rx_got.size() - rb), 32'(e_rx));
    for (int i = 0; i < e_rx; i++) begin
      exp = m_words[i] & wm;
      check({tag, " rx_data"}, (rb + i < rx_got.size()) ? rx_got[rb + i] : 32'hxxxx_xxxx, exp);
    end
    for (int i = 0; i < nwords; i++) begin
      exp = (tb0 + i < tx_exp.size()) ? (tx_exp[tb0 + i] & wm) : 32'hxxxx_xxxx;
      check({tag, " miso_word"}, m_got[i], exp);
    end
    check({tag, " tx_ready"}, 32'(c_txr - b_txr), 32'(e_txr));
    check({tag, " tx_underrun"}, 32'(c_unr - b_unr), 32'(e_unr));
    check({tag, " rx_overflow"}, 32'(c_ovf - b_ovf), 32'(e_ovf));
    check({tag, " frame_err"}, 32'(c_ferr - b_ferr), 32'(e_ferr));
    check({tag, " idle_lanes"}, 32'(lane_junk - b_junk), 32'd0);
  endtask

  typedef struct {
    string       tag;
    logic [1:0]  mode;
    logic        w32;
    int          nwords;
    int          cut;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        txv;
    logic [31:0] txd;
    logic        rdy;
    int          e_rx, e_txr, e_unr, e_ovf, e_ferr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          b_ferr, b_txr, rb;
    int          nw;
    logic [1:0]  md;
    logic        w32r;

    vecs[0] = '{"4l16", 2'd2, 1'b0, 1, 0, 32'hA5C3, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b1, 1, 1, 0, 0, 0};
    vecs[1] = '{"1l32", 2'd0, 1'b1, 1, 0, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 1, 1, 0, 0, 0};
    vecs[2] = '{"2l16burst", 2'd1, 1'b0, 2, 0, 32'h1234, 32'h5678, 1'b0, 32'h0, 1'b1, 2, 0, 2, 0, 0};
    vecs[3] = '{"4l16ovf", 2'd2, 1'b0, 2, 0, 32'h1111, 32'h2222, 1'b1, 32'hCAFE_0001, 1'b0, 0, 2, 0, 1, 0};
    vecs[4] = '{"1l16cut", 2'd0, 1'b0, 0, 8, 32'h00A5, 32'h0, 1'b1, 32'h55AA, 1'b1, 0, 1, 0, 0, 1};
    vecs[5] = '{"1l16beef", 2'd0, 1'b0, 1, 0, 32'hBEEF, 32'h0, 1'b1, 32'h7E57, 1'b1, 1, 1, 0, 0, 0};
    vecs[6] = '{"rsv32", 2'd3, 1'b1, 1, 0, 32'h0F1E_2D3C, 32'h0, 1'b1, 32'h8765_4321, 1'b1, 1, 1, 0, 0, 0};

    refill_pool(32'h0);
    repeat (3) @(negedge clk);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset spi_miso", 32'(spi_miso), 32'd0);
    check("reset rx_data", rx_data, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      tx_valid = vecs[v].txv;
      refill_pool(vecs[v].txd);
      rdy_fix = vecs[v].rdy;
      m_words[0] = vecs[v].w0;
      m_words[1] = vecs[v].w1;
      repeat (2) @(negedge clk);
      run_check(vecs[v].tag, vecs[v].mode, vecs[v].w32, vecs[v].nwords, vecs[v].cut,
                vecs[v].e_rx, vecs[v].e_txr, vecs[v].e_unr, vecs[v].e_ovf, vecs[v].e_ferr);
      if (vecs[v].rdy == 1'b0) begin
        // Held buffer keeps the first word until the consumer finally accepts it.
        check("ovf held_valid", 32'(rx_valid), 32'd1);
        check("ovf held_data", rx_data, 32'h1111);
        rb = rx_got.size();
        rdy_fix = 1'b1;
        repeat (2) @(negedge clk);
        check("ovf drained_valid", 32'(rx_valid), 32'd0);
        check("ovf drained_data", (rb < rx_got.size()) ? rx_got[rb] : 32'hxxxx_xxxx, 32'h1111);
      end
    end

    rdy_rand = 1'b1;
    for (int f = 0; f < 20; f++) begin
      md = 2'($urandom_range(0, 3));
      w32r = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) m_words[i] = $urandom;
      tx_valid = 1'($urandom_range(0, 1));
      refill_pool($urandom);
      repeat (2) @(negedge clk);
      run_check("rand", md, w32r, nw, 0, nw, tx_valid ? nw : 0, tx_valid ? 0 : nw, 0, 0);
    end
    rdy_rand = 1'b0;
    rdy_fix = 1'b1;

    // Reset in the middle of a 4-lane word.
    tx_valid = 1'b1;
    refill_pool(32'hFFFF_FFFF);
    lane_mode = 2'd2;
    word32 = 1'b0;
    spi_cs_n = 1'b0;
    repeat (10) @(negedge clk);
    spi_mosi = 4'h5;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst spi_miso", 32'(spi_miso), 32'd0);
    check("rst rx_data", rx_data, 32'd0);
    check("rst rx_valid", 32'(rx_valid), 32'd0);
    check("rst rx_overflow", 32'(rx_overflow), 32'd0);
    check("rst tx_ready", 32'(tx_ready), 32'd0);
    check("rst tx_underrun", 32'(tx_underrun), 32'd0);
    check("rst frame_err", 32'(frame_err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b_ferr = c_ferr;
    b_txr = c_txr;
    rb = rx_got.size();
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst frame_err", 32'(c_ferr - b_ferr), 32'd0);
    check("post_rst tx_ready", 32'(c_txr - b_txr), 32'd0);
    check("post_rst rx_words", 32'(rx_got.size() - rb), 32'd0);
    m_words[0] = 32'h00FF;
    refill_pool($urandom);
    run_check("post_rst", 2'd2, 1'b0, 1, 0, 1, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
